// File: rtl/acc_pkg.sv
// Shared types and default sizing for the accumulator serializer.
package acc_pkg;

    localparam int ACC_W       = 64;
    localparam int ACC_CLK_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } acc_state_e;

endpackage : acc_pkg

// File: rtl/acc_serializer_if.sv
// Snapshot request and framed serial link between the accumulator and acc_serializer.
interface acc_serializer_if #(
    parameter int DATA_WIDTH = acc_pkg::ACC_W
);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  start;
    logic                  ser_out;
    logic                  ser_clk;
    logic                  ser_frame;
    logic                  busy;
    logic                  done;

    modport master (
        output data_in,
        output start,
        input  ser_out,
        input  ser_clk,
        input  ser_frame,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  start,
        output ser_out,
        output ser_clk,
        output ser_frame,
        output busy,
        output done
    );

endinterface : acc_serializer_if

// File: rtl/acc_ser_bit_timer.sv
// Divides clk into serial bit periods: counts div_cnt, produces ser_clk and a bit_tick
// on the last cycle of each bit period.
module acc_ser_bit_timer
    import acc_pkg::*;
#(
    parameter int CLK_DIV = ACC_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic run_next,
    output logic bit_tick,
    output logic ser_clk
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             ser_clk_q;
    logic             ser_clk_d;

    // Next divider count; ser_clk is derived from the next count so it lines up with the data.
    always_comb begin
        div_cnt_d = DIV_W'(0);
        bit_tick  = 1'b0;
        if (run) begin
            bit_tick = (div_cnt_q == DIV_LAST);
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = DIV_W'(0);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            div_cnt_d = DIV_W'(0);
        end
        if (run_next) begin
            ser_clk_d = (div_cnt_d >= DIV_HALF);
        end else begin
            ser_clk_d = 1'b0;
        end
    end

    // Divider and bit clock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= DIV_W'(0);
            ser_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ser_clk_q <= ser_clk_d;
        end
    end

    assign ser_clk = ser_clk_q;

endmodule : acc_ser_bit_timer

// File: rtl/acc_serializer.sv
// Snapshots the accumulator on start and shifts it out MSB-first as a framed serial stream.
// Define ACC_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module acc_serializer
    import acc_pkg::*;
#(
    parameter int DATA_WIDTH = ACC_W,
    parameter int CLK_DIV    = ACC_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    acc_serializer_if.slave  bus
);

    localparam int BC_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);

    acc_state_e            state_q;
    acc_state_e            state_d;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_d;
    logic [BC_W-1:0]       bit_cnt_q;
    logic [BC_W-1:0]       bit_cnt_d;
    logic                  ser_out_q;
    logic                  ser_out_d;
    logic                  ser_frame_q;
    logic                  ser_frame_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;
    logic                  run_s;
    logic                  run_next_s;
    logic                  bit_tick_s;
`ifdef ACC_SERIALIZER_PARITY_EN
    logic                  parity_q;
    logic                  parity_d;
`endif

    assign run_s      = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign run_next_s = (state_d == ST_SHIFT) || (state_d == ST_PARITY);

    acc_ser_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run_s),
        .run_next (run_next_s),
        .bit_tick (bit_tick_s),
        .ser_clk  (bus.ser_clk)
    );

    // Next state, shift register and bit counter.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef ACC_SERIALIZER_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shreg_d   = bus.data_in;
                    bit_cnt_d = BC_W'(0);
`ifdef ACC_SERIALIZER_PARITY_EN
                    parity_d  = ^bus.data_in;
`endif
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_tick_s) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = BC_W'(0);
`ifdef ACC_SERIALIZER_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_DONE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
`ifdef ACC_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered pins track the FSM cycle-exactly.
    always_comb begin
        ser_out_d   = 1'b0;
        ser_frame_d = run_next_s;
        busy_d      = run_next_s;
        done_d      = (state_d == ST_DONE);
        case (state_d)
            ST_SHIFT: begin
                ser_out_d = shreg_d[DATA_WIDTH-1];
            end
`ifdef ACC_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                ser_out_d = parity_d;
            end
`endif
            default: begin
                ser_out_d = 1'b0;
            end
        endcase
    end

    // FSM state, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= BC_W'(0);
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ACC_SERIALIZER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_frame_q <= ser_frame_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef ACC_SERIALIZER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.ser_out   = ser_out_q;
    assign bus.ser_frame = ser_frame_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule : acc_serializer
